// File: rtl/mem_arbiter_if.sv
// Cache-side request/response signals and the shared RAM port of the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic        busy;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, busy, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the single RAM port to instruction fetch or data access,
// holding the grant until ACCESS, ERROR, timeout or requester abort.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_e;
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_st_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              wen_q, wen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       store_q, store_d;

    ram_st_e           ram_st;
    logic              req_i, req_d;
    logic              pick_d;
    logic              granted_en;
    logic              timeout;
    logic              ram_ren, ram_wen;
    logic              ihit_c, dhit_c;

    always_comb begin
        ram_st     = ram_st_e'(bus.ramstate);
        req_i      = bus.iREN;
        req_d      = bus.dREN | bus.dWEN;
        // On a tie the requester that did not win last time gets the port
        pick_d     = req_d & (~req_i | ~last_q);
        granted_en = (state_q == IGNT) ? req_i : req_d;
        timeout    = (cnt_q == CNT_W'(TIMEOUT));
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        err_d   = err_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        ihit_c  = 1'b0;
        dhit_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i | req_d) begin
                    cnt_d = '0;
                    if (pick_d) begin
                        state_d = DGNT;
                        wen_d   = bus.dWEN;
                        addr_d  = bus.daddr;
                        store_d = bus.dstore;
                    end else begin
                        state_d = IGNT;
                        wen_d   = 1'b0;
                        addr_d  = bus.iaddr;
                        store_d = '0;
                    end
                end
            end

            IGNT, DGNT: begin
                ram_ren = ~wen_q;
                ram_wen = wen_q;
                // ACCESS outranks abort and timeout; abort outranks a RAM error
                if (ram_st == RAM_ACCESS) begin
                    ihit_c  = (state_q == IGNT);
                    dhit_c  = (state_q == DGNT);
                    last_d  = (state_q == DGNT);
                    state_d = IDLE;
                end else if (!granted_en) begin
                    ram_ren = 1'b0;
                    ram_wen = 1'b0;
                    state_d = IDLE;
                end else if ((ram_st == RAM_ERROR) || timeout) begin
                    err_d   = 1'b1;
                    last_d  = (state_q == DGNT);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        bus.ramREN   = ram_ren;
        bus.ramWEN   = ram_wen;
        bus.ramaddr  = (state_q == IDLE) ? '0 : addr_q;
        bus.ramstore = (state_q == IDLE) ? '0 : store_q;
        bus.ihit     = ihit_c;
        bus.dhit     = dhit_c;
        bus.iload    = ihit_c ? bus.ramload : '0;
        bus.dload    = dhit_c ? bus.ramload : '0;
        bus.busy     = (state_q != IDLE);
        bus.err      = err_q;
    end

endmodule
